// File: rtl/sram_frame_reader.sv
// Reads framed host-TX words from the shared SRAM FIFO and streams the length byte and
// payload bytes to the radio TX loader. It checks the sync word and the length, and drops the pad byte.
//
// state | meaning
// IDLE  | waiting for enable and a non-empty FIFO
// SYNC  | reading the sync word
// LEN   | reading {00, N}
// FIRST | reading {L, D0} and checking L against N-1
// WORD  | reading the next payload pair
// HI    | presenting word[15:8]
// LO    | presenting word[7:0]
// DONE  | frame complete pulse
module sram_frame_reader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        SRAM_read,
  input  logic        SRAM_hint,
  input  logic [15:0] Data_from_sram,
  input  logic        SRAM_empty,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        frame_start,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic        sync_err,
  output logic        len_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, SYNC, LEN, FIRST, WORD, HI, LO, DONE
  } state_t;

  localparam logic [15:0] SYNC_WORD = 16'h2DD4;

  state_t      r_state, w_state_nxt;
  logic        r_rd, w_rd_nxt;
  logic [15:0] r_word, w_word_nxt;
  logic [7:0]  r_rem, w_rem_nxt;
  logic [7:0]  r_len, w_len_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_valid, r_start, r_done, r_serr, r_lerr, r_busy;
  logic        w_start, w_serr, w_lerr;
  logic        w_ack, w_xfer, w_rd_state;

  assign w_ack      = r_rd & SRAM_hint;
  assign w_xfer     = r_valid & byte_ready;
  assign w_rd_state = (r_state == SYNC) || (r_state == LEN) ||
                      (r_state == FIRST) || (r_state == WORD);

  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = r_rd;
    w_word_nxt  = r_word;
    w_rem_nxt   = r_rem;
    w_len_nxt   = r_len;
    w_data_nxt  = r_data;
    w_start     = 1'b0;
    w_serr      = 1'b0;
    w_lerr      = 1'b0;

    // A request is only ever dropped by its acknowledge, so the read strobe
    // is low for at least one cycle before the next request can start.
    if (w_rd_state) begin
      if (w_ack) begin
        w_rd_nxt = 1'b0;
      end else if (!r_rd && !SRAM_empty) begin
        w_rd_nxt = 1'b1;
      end
    end

    case (r_state)
      IDLE: begin
        if (enable && !SRAM_empty) w_state_nxt = SYNC;
      end
      SYNC: begin
        if (w_ack) begin
          if (Data_from_sram == SYNC_WORD) begin
            w_state_nxt = LEN;
          end else begin
            w_serr      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      LEN: begin
        if (w_ack) begin
          if ((Data_from_sram[15:8] != 8'h00) || (Data_from_sram[7:0] < 8'd2)) begin
            w_lerr      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_rem_nxt   = Data_from_sram[7:0];
            w_len_nxt   = Data_from_sram[7:0] - 8'd1;
            w_state_nxt = FIRST;
          end
        end
      end
      FIRST: begin
        if (w_ack) begin
          if (Data_from_sram[15:8] != r_len) begin
            w_lerr      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_word_nxt  = Data_from_sram;
            w_data_nxt  = Data_from_sram[15:8];
            w_start     = 1'b1;
            w_state_nxt = HI;
          end
        end
      end
      WORD: begin
        if (w_ack) begin
          w_word_nxt  = Data_from_sram;
          w_data_nxt  = Data_from_sram[15:8];
          w_state_nxt = HI;
        end
      end
      HI: begin
        if (w_xfer) begin
          w_rem_nxt = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_state_nxt = DONE;
          end else begin
            w_data_nxt  = r_word[7:0];
            w_state_nxt = LO;
          end
        end
      end
      LO: begin
        if (w_xfer) begin
          w_rem_nxt   = r_rem - 8'd1;
          w_state_nxt = (r_rem == 8'd1) ? DONE : WORD;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_word  <= 16'h0000;
      r_rem   <= 8'h00;
      r_len   <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_serr  <= 1'b0;
      r_lerr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rd    <= w_rd_nxt;
      r_word  <= w_word_nxt;
      r_rem   <= w_rem_nxt;
      r_len   <= w_len_nxt;
      r_data  <= w_data_nxt;
      r_valid <= (w_state_nxt == HI) || (w_state_nxt == LO);
      r_start <= w_start;
      r_done  <= (w_state_nxt == DONE);
      r_serr  <= w_serr;
      r_lerr  <= w_lerr;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign SRAM_read   = r_rd;
  assign byte_data   = r_data;
  assign byte_valid  = r_valid;
  assign frame_start = r_start;
  assign frame_done  = r_done;
  assign frame_len   = r_len;
  assign sync_err    = r_serr;
  assign len_err     = r_lerr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader: an SRAM FIFO responder with configurable hint latency,
// a byte/pulse monitor, and a linear sequence of frame scenarios with hand-computed expectations.
module tb_sram_frame_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        SRAM_hint = 1'b0;
  logic        SRAM_empty = 1'b1;
  logic        byte_ready = 1'b1;
  logic [15:0] Data_from_sram = 16'h0000;
  logic        SRAM_read, byte_valid, frame_start, frame_done, sync_err, len_err, busy;
  logic [7:0]  byte_data, frame_len;

  logic [15:0] q[$];
  logic [7:0]  got[$];
  int n_cmp = 0, n_err = 0;
  int n_reads = 0, n_start = 0, n_done = 0, n_serr = 0, n_lerr = 0, n_vcyc = 0;
  int done_at = 0, lat = 0, cnt = 0, rd_hi = 0;
  logic [7:0] start_byte = 8'h00;
  logic       start_v = 1'b0;

  sram_frame_reader dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .SRAM_read(SRAM_read), .SRAM_hint(SRAM_hint), .Data_from_sram(Data_from_sram),
    .SRAM_empty(SRAM_empty), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .frame_start(frame_start), .frame_done(frame_done),
    .frame_len(frame_len), .sync_err(sync_err), .len_err(len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM responder: hint arrives lat+1 cycles after the request rises
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      SRAM_hint = 1'b0;
      cnt = 0;
    end else if (SRAM_hint) begin
      SRAM_hint = 1'b0;
    end else if (SRAM_read && q.size() > 0) begin
      if (cnt >= lat) begin
        SRAM_hint = 1'b1;
        Data_from_sram = q.pop_front();
        n_reads++;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    SRAM_empty = (q.size() == 0);
  end

  always @(negedge clk) begin
    if (byte_valid) n_vcyc++;
    if (byte_valid && byte_ready) got.push_back(byte_data);
    if (frame_start) begin
      n_start++;
      start_byte = byte_data;
      start_v = byte_valid;
    end
    if (frame_done) begin
      n_done++;
      done_at = got.size();
    end
    if (sync_err) n_serr++;
    if (len_err) n_lerr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats;
    got.delete();
    n_reads = 0; n_start = 0; n_done = 0; n_serr = 0; n_lerr = 0; n_vcyc = 0;
    done_at = 0; start_byte = 8'h00; start_v = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push4(input logic [63:0] w);
    q.push_back(w[63:48]);
    q.push_back(w[47:32]);
    q.push_back(w[31:16]);
    q.push_back(w[15:0]);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    do begin
      tick(1);
      i++;
    end while (!(q.size() == 0 && !busy && !SRAM_hint) && i < 2000);
    check({tag, "_timeout"}, 32'(i < 2000), 1);
    tick(2);
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] exp, input int n);
    check({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check({tag, "_byte"}, 32'(got[i]), 32'(exp[8*(n-1-i) +: 8]));
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!byte_valid && i < 200) begin
      tick(1);
      i++;
    end
    check({tag, "_valid_timeout"}, 32'(i < 200), 1);
  endtask

  logic [31:0] bp_exp;

  initial begin
    // reset values
    #2;
    check("rst_outputs", 32'({SRAM_read, byte_valid, byte_data, frame_start, frame_done,
                              frame_len, sync_err, len_err, busy}), 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // L=3 frame
    clear_stats();
    lat = 0;
    enable = 1'b1;
    push4(64'h2DD4_0004_03A1_A2A3);
    wait_idle("l3");
    check_bytes("l3", 32'h03A1A2A3, 4);
    check("l3_start_cnt", 32'(n_start), 1);
    check("l3_start_byte", 32'(start_byte), 'h03);
    check("l3_start_valid", 32'(start_v), 1);
    check("l3_done_cnt", 32'(n_done), 1);
    check("l3_done_after_last", 32'(done_at), 4);
    check("l3_frame_len", 32'(frame_len), 3);
    check("l3_reads", 32'(n_reads), 4);

    // L=2, padding dropped
    clear_stats();
    push4(64'h2DD4_0003_02B1_B200);
    wait_idle("l2");
    check_bytes("l2", 32'h0002B1B2, 3);
    check("l2_reads", 32'(n_reads), 4);
    check("l2_done_cnt", 32'(n_done), 1);
    check("l2_frame_len", 32'(frame_len), 2);

    // bad sync then resync, slower SRAM
    clear_stats();
    lat = 2;
    push4(64'h1234_2DD4_0002_01C5);
    wait_idle("sync");
    check("sync_err_cnt", 32'(n_serr), 1);
    check_bytes("sync", 32'h000001C5, 2);
    check("sync_done_cnt", 32'(n_done), 1);
    check("sync_frame_len", 32'(frame_len), 1);
    lat = 0;

    // length mismatch in the first data word
    clear_stats();
    q.push_back(16'h2DD4);
    q.push_back(16'h0004);
    q.push_back(16'h05AA);
    wait_idle("mism");
    check("mism_len_err", 32'(n_lerr), 1);
    check("mism_no_valid", 32'(n_vcyc), 0);
    check("mism_no_done", 32'(n_done), 0);
    check("mism_reads", 32'(n_reads), 3);
    check("mism_frame_len", 32'(frame_len), 3);

    // N wrapped to 0 by L=255
    clear_stats();
    q.push_back(16'h2DD4);
    q.push_back(16'h0000);
    wait_idle("wrap");
    check("wrap_len_err", 32'(n_lerr), 1);
    check("wrap_no_valid", 32'(n_vcyc), 0);
    check("wrap_frame_len", 32'(frame_len), 3);

    // backpressure: hold A2 for 5 cycles
    clear_stats();
    byte_ready = 1'b0;
    bp_exp = 32'h03A1A2A3;
    push4(64'h2DD4_0004_03A1_A2A3);
    for (int k = 0; k < 4; k++) begin
      wait_valid("bp");
      check("bp_byte", 32'(byte_data), 32'(bp_exp[8*(3-k) +: 8]));
      if (k == 2) begin
        for (int s = 0; s < 5; s++) begin
          tick(1);
          check("bp_hold", 32'({byte_valid, byte_data}), 'h1A2);
        end
      end
      byte_ready = 1'b1;
      tick(1);
      byte_ready = 1'b0;
    end
    byte_ready = 1'b1;
    wait_idle("bp");
    check_bytes("bp", 32'h03A1A2A3, 4);
    check("bp_done_cnt", 32'(n_done), 1);

    // SRAM empty for 10 cycles before the first data word
    clear_stats();
    q.push_back(16'h2DD4);
    q.push_back(16'h0004);
    begin
      int i;
      i = 0;
      while (!(q.size() == 0 && !SRAM_hint) && i < 200) begin
        tick(1);
        i++;
      end
      check("empty_reach_timeout", 32'(i < 200), 1);
    end
    rd_hi = 0;
    for (int s = 0; s < 10; s++) begin
      tick(1);
      if (SRAM_read) rd_hi++;
    end
    check("empty_no_read", 32'(rd_hi), 0);
    check("empty_busy", 32'(busy), 1);
    q.push_back(16'h03A1);
    q.push_back(16'hA2A3);
    wait_idle("empty");
    check_bytes("empty", 32'h03A1A2A3, 4);
    check("empty_done_cnt", 32'(n_done), 1);

    // reset mid-frame after A1
    clear_stats();
    push4(64'h2DD4_0004_03A1_A2A3);
    begin
      int i;
      i = 0;
      while (got.size() < 2 && i < 200) begin
        tick(1);
        i++;
      end
      check("rstmid_reach_timeout", 32'(i < 200), 1);
    end
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check("rstmid_outputs", 32'({SRAM_read, byte_valid, byte_data, frame_start, frame_done,
                                 frame_len, sync_err, len_err, busy}), 0);
    q.delete();
    tick(3);
    check("rstmid_no_done", 32'(n_done), 0);
    reset_n = 1'b1;
    tick(2);

    // enable gating, then a fresh frame
    clear_stats();
    push4(64'h2DD4_0004_03A1_A2A3);
    rd_hi = 0;
    for (int s = 0; s < 20; s++) begin
      tick(1);
      if (SRAM_read) rd_hi++;
    end
    check("gate_no_read", 32'(rd_hi), 0);
    check("gate_reads", 32'(n_reads), 0);
    check("gate_busy", 32'(busy), 0);
    enable = 1'b1;
    wait_idle("gate");
    check_bytes("gate", 32'h03A1A2A3, 4);
    check("gate_done_cnt", 32'(n_done), 1);
    check("gate_frame_len", 32'(frame_len), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
